// File: rtl/mem_arbiter_pkg.sv
// Shared memory-port definitions: state codes, requester ids and bus widths.
// Imported by the arbiter and by both cache controllers.
package mem_arbiter_pkg;

    localparam int ADDR_W  = 28;
    localparam int BLOCK_W = 256;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] I_BUSY = 2'b01;
    localparam logic [1:0] D_BUSY = 2'b10;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    function automatic logic [1:0] busy_state(input req_id_t id);
        return (id == REQ_D) ? D_BUSY : I_BUSY;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// I-cache, D-cache and memory-side signals of the shared 256-bit port.
// slave = arbiter view, master = the caches plus memory around it.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int BW = BLOCK_W
) ();
    logic [AW-1:0] i_mem_addr;
    logic          i_mem_valid;
    logic [BW-1:0] i_mem_rd;
    logic          i_mem_ready;

    logic [AW-1:0] d_mem_addr;
    logic [BW-1:0] d_mem_wr;
    logic          d_mem_rw;
    logic          d_mem_valid;
    logic [BW-1:0] d_mem_rd;
    logic          d_mem_ready;

    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_wr;
    logic          mem_rw;
    logic          mem_valid;
    logic [BW-1:0] mem_rd;
    logic          mem_ready;

    modport slave (
        input  i_mem_addr, i_mem_valid,
        output i_mem_rd, i_mem_ready,
        input  d_mem_addr, d_mem_wr, d_mem_rw, d_mem_valid,
        output d_mem_rd, d_mem_ready,
        output mem_addr, mem_wr, mem_rw, mem_valid,
        input  mem_rd, mem_ready
    );

    modport master (
        output i_mem_addr, i_mem_valid,
        input  i_mem_rd, i_mem_ready,
        output d_mem_addr, d_mem_wr, d_mem_rw, d_mem_valid,
        input  d_mem_rd, d_mem_ready,
        input  mem_addr, mem_wr, mem_rw, mem_valid,
        output mem_rd, mem_ready
    );
endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick between I and D requests; purely combinational.
// No backpressure of its own: the caller only samples the pick when the port is free.
module mem_arbiter_rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic    req_i_vld,
    input  logic    req_d_vld,
    input  req_id_t last_grant,
    output logic    gnt_vld,
    output req_id_t gnt_id
);

    always_comb begin
        gnt_vld = req_i_vld | req_d_vld;
        gnt_id  = REQ_I;
        if (req_i_vld && req_d_vld) begin
            // Tie goes to whoever did not finish the previous transaction.
            if (last_grant == REQ_D) gnt_id = REQ_I;
            else                     gnt_id = REQ_D;
        end else if (req_d_vld) begin
            gnt_id = REQ_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin owner of the shared memory port; grant visible one cycle after request.
// Owner holds the port until mem_ready, then one idle turnaround cycle; timeout is flag-only.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int BLOCK_SIZE = BLOCK_W,
    parameter int TIMEOUT    = 1023
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus,
    output logic          grant_d,
    output logic          bus_timeout
);

    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [BLOCK_SIZE-1:0] wr;
        logic                  rw;
        logic                  valid;
    } mem_req_t;

    logic [1:0]       state_q, state_d;
    req_id_t          last_grant_q, last_grant_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             bus_timeout_q, bus_timeout_d;

    logic     pick_vld;
    req_id_t  pick_id;
    logic     busy;
    logic     owner_valid;
    mem_req_t mem_req;

    mem_arbiter_rr_arbiter2 u_rr_arbiter2 (
        .req_i_vld  (bus.i_mem_valid),
        .req_d_vld  (bus.d_mem_valid),
        .last_grant (last_grant_q),
        .gnt_vld    (pick_vld),
        .gnt_id     (pick_id)
    );

    assign busy = (state_q == I_BUSY) || (state_q == D_BUSY);

    always_comb begin
        owner_valid = 1'b0;
        if (state_q == I_BUSY) owner_valid = bus.i_mem_valid;
        if (state_q == D_BUSY) owner_valid = bus.d_mem_valid;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) state_d = busy_state(pick_id);
            end
            I_BUSY, D_BUSY: begin
                if (bus.mem_ready) begin
                    state_d      = IDLE;
                    last_grant_d = (state_q == D_BUSY) ? REQ_D : REQ_I;
                end else if (!owner_valid) begin
                    // Withdrawn request: release the port without counting it as a turn.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tmo_cnt_d = '0;
        if (busy && !bus.mem_ready) begin
            tmo_cnt_d = (tmo_cnt_q == CNT_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
        end
        bus_timeout_d = bus_timeout_q | (tmo_cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= REQ_D;
            tmo_cnt_q     <= '0;
            bus_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            tmo_cnt_q     <= tmo_cnt_d;
            bus_timeout_q <= bus_timeout_d;
        end
    end

    // Memory side follows the owner combinationally; the I-cache only ever reads.
    always_comb begin
        mem_req = '0;
        case (state_q)
            I_BUSY: begin
                mem_req.addr  = bus.i_mem_addr;
                mem_req.valid = bus.i_mem_valid;
            end
            D_BUSY: begin
                mem_req.addr  = bus.d_mem_addr;
                mem_req.wr    = bus.d_mem_wr;
                mem_req.rw    = bus.d_mem_rw;
                mem_req.valid = bus.d_mem_valid;
            end
            default: mem_req = '0;
        endcase
    end

    assign bus.mem_addr  = mem_req.addr;
    assign bus.mem_wr    = mem_req.wr;
    assign bus.mem_rw    = mem_req.rw;
    assign bus.mem_valid = mem_req.valid;

    assign bus.i_mem_ready = bus.mem_ready & (state_q == I_BUSY);
    assign bus.d_mem_ready = bus.mem_ready & (state_q == D_BUSY);
    assign bus.i_mem_rd    = (state_q == I_BUSY) ? bus.mem_rd : '0;
    assign bus.d_mem_rd    = (state_q == D_BUSY) ? bus.mem_rd : '0;

    assign grant_d     = (state_q == D_BUSY);
    assign bus_timeout = bus_timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int TMO = 1023;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic grant_d;
    logic bus_timeout;
    int   checks = 0;
    int   failures = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .grant_d     (grant_d),
        .bus_timeout (bus_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_mem_addr  = '0;
        bus.i_mem_valid = 1'b0;
        bus.d_mem_addr  = '0;
        bus.d_mem_wr    = '0;
        bus.d_mem_rw    = 1'b0;
        bus.d_mem_valid = 1'b0;
        bus.mem_rd      = '0;
        bus.mem_ready   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        bus.i_mem_valid = 1'b1;
        bus.d_mem_valid = 1'b1;
        bus.mem_ready   = 1'b1;
        bus.mem_rd      = rnd256();
        cyc();
        checks++;
        if ({bus.mem_valid, bus.mem_rw, bus.i_mem_ready, bus.d_mem_ready, grant_d, bus_timeout} !== 6'b0 ||
            bus.mem_addr !== '0 || bus.mem_wr !== '0 || bus.i_mem_rd !== '0 || bus.d_mem_rd !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got vld=%b rw=%b ir=%b dr=%b gd=%b to=%b addr=%h, want all zero",
                     bus.mem_valid, bus.mem_rw, bus.i_mem_ready, bus.d_mem_ready, grant_d, bus_timeout, bus.mem_addr);
        end
        // Out of reset with a stray mem_ready in IDLE: nothing is routed anywhere.
        bus.i_mem_valid = 1'b0;
        bus.d_mem_valid = 1'b0;
        rst_n = 1'b1;
        cyc();
        checks++;
        if ({bus.mem_valid, bus.i_mem_ready, bus.d_mem_ready, grant_d} !== 4'b0 ||
            bus.i_mem_rd !== '0 || bus.d_mem_rd !== '0) begin
            failures++;
            $display("FAIL idle_ready_ignored: got vld=%b ir=%b dr=%b gd=%b, want 0 0 0 0",
                     bus.mem_valid, bus.i_mem_ready, bus.d_mem_ready, grant_d);
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_lone_i_read();
        logic [255:0] data;
        data = {8{32'hA5A5_0001}};
        do_reset();
        bus.i_mem_valid = 1'b1;
        bus.i_mem_addr  = 28'h0001230;
        #1;
        checks++;
        if (bus.mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL lone_i_c0: mem_valid=%b want 0", bus.mem_valid);
        end
        cyc();
        checks++;
        if (bus.mem_valid !== 1'b1 || bus.mem_rw !== 1'b0 || bus.mem_addr !== 28'h0001230 || grant_d !== 1'b0) begin
            failures++;
            $display("FAIL lone_i_c1: vld=%b rw=%b addr=%h gd=%b want 1 0 0001230 0",
                     bus.mem_valid, bus.mem_rw, bus.mem_addr, grant_d);
        end
        cyc();
        cyc();
        cyc();
        bus.mem_ready = 1'b1;
        bus.mem_rd    = data;
        #1;
        checks++;
        if (bus.i_mem_ready !== 1'b1 || bus.i_mem_rd !== data || bus.d_mem_ready !== 1'b0 || bus.d_mem_rd !== '0) begin
            failures++;
            $display("FAIL lone_i_c4: ir=%b ird=%h dr=%b want 1 %h 0", bus.i_mem_ready, bus.i_mem_rd, bus.d_mem_ready, data);
        end
        cyc();
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.mem_valid !== 1'b0 || grant_d !== 1'b0) begin
            failures++;
            $display("FAIL lone_i_c5_idle: vld=%b gd=%b want 0 0", bus.mem_valid, grant_d);
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_simultaneous();
        logic [255:0] w;
        w = rnd256();
        do_reset();
        bus.i_mem_valid = 1'b1;
        bus.i_mem_addr  = 28'h0007770;
        bus.d_mem_valid = 1'b1;
        bus.d_mem_addr  = 28'h0333338;
        bus.d_mem_rw    = 1'b1;
        bus.d_mem_wr    = w;
        cyc();
        checks++;
        if (grant_d !== 1'b0 || bus.mem_valid !== 1'b1 || bus.mem_addr !== 28'h0007770 || bus.mem_rw !== 1'b0) begin
            failures++;
            $display("FAIL simul_first_i: gd=%b vld=%b addr=%h rw=%b want 0 1 0007770 0",
                     grant_d, bus.mem_valid, bus.mem_addr, bus.mem_rw);
        end
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (bus.i_mem_ready !== 1'b1 || bus.d_mem_ready !== 1'b0) begin
            failures++;
            $display("FAIL simul_i_ready: ir=%b dr=%b want 1 0", bus.i_mem_ready, bus.d_mem_ready);
        end
        cyc();
        bus.mem_ready   = 1'b0;
        bus.i_mem_valid = 1'b0;
        #1;
        checks++;
        if (bus.mem_valid !== 1'b0 || grant_d !== 1'b0) begin
            failures++;
            $display("FAIL simul_turnaround: vld=%b gd=%b want 0 0", bus.mem_valid, grant_d);
        end
        cyc();
        checks++;
        if (grant_d !== 1'b1 || bus.mem_rw !== 1'b1 || bus.mem_wr !== w || bus.mem_addr !== 28'h0333338) begin
            failures++;
            $display("FAIL simul_then_d: gd=%b rw=%b addr=%h wr=%h want 1 1 0333338 %h",
                     grant_d, bus.mem_rw, bus.mem_addr, bus.mem_wr, w);
        end
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (bus.d_mem_ready !== 1'b1 || bus.i_mem_ready !== 1'b0) begin
            failures++;
            $display("FAIL simul_d_ready: dr=%b ir=%b want 1 0", bus.d_mem_ready, bus.i_mem_ready);
        end
        cyc();
        idle_inputs();
        cyc();
    endtask

    task automatic test_flush();
        string ord;
        string exp_ord;
        byte   exp_c;
        int    wait_n;
        int    d_done;
        logic  seen_d;
        logic  post_d;
        logic  post_i;
        exp_ord = "DIDDD";
        ord = "";
        wait_n = 0;
        d_done = 0;
        seen_d = 1'b0;
        post_d = 1'b0;
        post_i = 1'b0;
        do_reset();
        bus.d_mem_valid = 1'b1;
        bus.d_mem_rw    = 1'b1;
        bus.d_mem_addr  = 28'h0100000;
        bus.d_mem_wr    = rnd256();
        for (int c = 0; c < 200 && ord.len() < 5; c++) begin
            bus.mem_ready = 1'b0;
            bus.mem_rd    = '0;
            if (post_d) begin
                d_done++;
                if (d_done == 4) bus.d_mem_valid = 1'b0;
                else begin
                    bus.d_mem_addr = bus.d_mem_addr + 28'd8;
                    bus.d_mem_wr   = rnd256();
                end
            end
            if (post_i) bus.i_mem_valid = 1'b0;
            post_d = 1'b0;
            post_i = 1'b0;
            #1;
            if (bus.mem_valid) begin
                if (grant_d && !seen_d) begin
                    seen_d = 1'b1;
                    bus.i_mem_valid = 1'b1;
                    bus.i_mem_addr  = 28'h0002000;
                end
                wait_n++;
                if (wait_n == 3) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rd    = rnd256();
                    #1;
                    exp_c = exp_ord[ord.len()];
                    checks++;
                    if (bus.i_mem_ready !== (exp_c == "I") || bus.d_mem_ready !== (exp_c == "D") ||
                        bus.i_mem_rd !== ((exp_c == "I") ? bus.mem_rd : 256'd0) ||
                        bus.d_mem_rd !== ((exp_c == "D") ? bus.mem_rd : 256'd0)) begin
                        failures++;
                        $display("FAIL flush_route[%0d]: ir=%b dr=%b want owner %c only",
                                 ord.len(), bus.i_mem_ready, bus.d_mem_ready, exp_c);
                    end
                    ord = {ord, grant_d ? "D" : "I"};
                    if (grant_d) post_d = 1'b1;
                    else         post_i = 1'b1;
                    wait_n = 0;
                end
            end else begin
                wait_n = 0;
            end
            cyc();
        end
        checks++;
        if (ord != exp_ord) begin
            failures++;
            $display("FAIL flush_order: got %s want %s", ord, exp_ord);
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_wb_allocate();
        do_reset();
        bus.d_mem_valid = 1'b1;
        bus.d_mem_rw    = 1'b1;
        bus.d_mem_addr  = 28'h0456780;
        bus.d_mem_wr    = rnd256();
        cyc();
        checks++;
        if (bus.mem_valid !== 1'b1 || bus.mem_rw !== 1'b1 || bus.mem_addr !== 28'h0456780) begin
            failures++;
            $display("FAIL wb_write: vld=%b rw=%b addr=%h want 1 1 0456780", bus.mem_valid, bus.mem_rw, bus.mem_addr);
        end
        bus.mem_ready = 1'b1;
        cyc();
        bus.mem_ready  = 1'b0;
        bus.d_mem_rw   = 1'b0;
        bus.d_mem_addr = 28'h0999780;
        #1;
        checks++;
        if (bus.mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL wb_no_duplicate: vld=%b rw=%b want vld 0", bus.mem_valid, bus.mem_rw);
        end
        cyc();
        checks++;
        if (bus.mem_valid !== 1'b1 || bus.mem_rw !== 1'b0 || bus.mem_addr !== 28'h0999780) begin
            failures++;
            $display("FAIL wb_allocate_read: vld=%b rw=%b addr=%h want 1 0 0999780", bus.mem_valid, bus.mem_rw, bus.mem_addr);
        end
        bus.mem_ready = 1'b1;
        cyc();
        idle_inputs();
        cyc();
    endtask

    task automatic test_random();
        int   own;      // 0 = nobody, 1 = I-cache, 2 = D-cache
        logic last_is_d;
        int   stall;
        logic tmo;
        logic [27:0]  e_addr;
        logic [255:0] e_wr;
        logic [255:0] e_ird;
        logic [255:0] e_drd;
        logic e_rw, e_vld, e_ir, e_dr;
        logic own_vld;
        do_reset();
        own = 0;
        last_is_d = 1'b1;
        stall = 0;
        tmo = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom % 4 == 0) bus.i_mem_valid = ~bus.i_mem_valid;
            if ($urandom % 4 == 0) bus.d_mem_valid = ~bus.d_mem_valid;
            bus.i_mem_addr = 28'($urandom) & 28'hFFFFFF8;
            bus.d_mem_addr = 28'($urandom) & 28'hFFFFFF8;
            bus.d_mem_wr   = rnd256();
            bus.d_mem_rw   = 1'($urandom % 2);
            bus.mem_ready  = ($urandom % 3 == 0);
            bus.mem_rd     = rnd256();
            #1;
            e_vld  = (own == 1) ? bus.i_mem_valid : (own == 2) ? bus.d_mem_valid : 1'b0;
            e_addr = (own == 1) ? bus.i_mem_addr : (own == 2) ? bus.d_mem_addr : 28'd0;
            e_rw   = (own == 2) ? bus.d_mem_rw : 1'b0;
            e_wr   = (own == 2) ? bus.d_mem_wr : 256'd0;
            e_ir   = bus.mem_ready && own == 1;
            e_dr   = bus.mem_ready && own == 2;
            e_ird  = (own == 1) ? bus.mem_rd : 256'd0;
            e_drd  = (own == 2) ? bus.mem_rd : 256'd0;
            checks++;
            if (bus.mem_valid !== e_vld || bus.mem_addr !== e_addr || bus.mem_rw !== e_rw || bus.mem_wr !== e_wr) begin
                failures++;
                $display("FAIL rand_mem_side[%0d]: vld=%b addr=%h rw=%b want %b %h %b (owner %0d)",
                         c, bus.mem_valid, bus.mem_addr, bus.mem_rw, e_vld, e_addr, e_rw, own);
            end
            checks++;
            if (bus.i_mem_ready !== e_ir || bus.d_mem_ready !== e_dr || bus.i_mem_rd !== e_ird || bus.d_mem_rd !== e_drd) begin
                failures++;
                $display("FAIL rand_return[%0d]: ir=%b dr=%b want %b %b (owner %0d)",
                         c, bus.i_mem_ready, bus.d_mem_ready, e_ir, e_dr, own);
            end
            checks++;
            if (grant_d !== (own == 2) || bus_timeout !== tmo) begin
                failures++;
                $display("FAIL rand_status[%0d]: gd=%b to=%b want %b %b", c, grant_d, bus_timeout, own == 2, tmo);
            end
            // Advance the transaction-level model across the coming edge.
            if (own == 0) begin
                stall = 0;
                if (bus.i_mem_valid && bus.d_mem_valid) own = last_is_d ? 1 : 2;
                else if (bus.i_mem_valid)               own = 1;
                else if (bus.d_mem_valid)               own = 2;
            end else if (bus.mem_ready) begin
                last_is_d = (own == 2);
                own = 0;
                stall = 0;
            end else begin
                own_vld = (own == 1) ? bus.i_mem_valid : bus.d_mem_valid;
                if (stall < TMO) stall++;
                if (stall >= TMO) tmo = 1'b1;
                if (!own_vld) own = 0;
            end
            cyc();
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_timeout();
        do_reset();
        bus.i_mem_valid = 1'b1;
        bus.i_mem_addr  = 28'h0040000;
        cyc();
        for (int s = 0; s <= TMO; s++) begin
            if (s == TMO - 1) begin
                checks++;
                if (bus_timeout !== 1'b0) begin
                    failures++;
                    $display("FAIL timeout_early: after %0d stalls got %b want 0", s, bus_timeout);
                end
            end
            if (s == TMO) begin
                checks++;
                if (bus_timeout !== 1'b1 || bus.mem_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL timeout_at_limit: after %0d stalls to=%b vld=%b want 1 1", s, bus_timeout, bus.mem_valid);
                end
            end
            if (s < TMO) cyc();
        end
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (bus.i_mem_ready !== 1'b1) begin
            failures++;
            $display("FAIL timeout_late_ready: ir=%b want 1", bus.i_mem_ready);
        end
        cyc();
        bus.mem_ready   = 1'b0;
        bus.i_mem_valid = 1'b0;
        cyc();
        cyc();
        checks++;
        if (bus_timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky: got %b want 1", bus_timeout);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_reset_clear: got %b want 0", bus_timeout);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.d_mem_valid = 1'b1;
        bus.d_mem_rw    = 1'b1;
        bus.d_mem_addr  = 28'h0ABCDE8;
        bus.d_mem_wr    = rnd256();
        cyc();
        checks++;
        if (grant_d !== 1'b1 || bus.mem_valid !== 1'b1) begin
            failures++;
            $display("FAIL midrst_setup: gd=%b vld=%b want 1 1", grant_d, bus.mem_valid);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rd    = rnd256();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_valid, bus.mem_rw, bus.i_mem_ready, bus.d_mem_ready, grant_d, bus_timeout} !== 6'b0 ||
            bus.mem_addr !== '0 || bus.mem_wr !== '0 || bus.i_mem_rd !== '0 || bus.d_mem_rd !== '0) begin
            failures++;
            $display("FAIL midrst_async_zero: vld=%b rw=%b ir=%b dr=%b gd=%b addr=%h want all zero",
                     bus.mem_valid, bus.mem_rw, bus.i_mem_ready, bus.d_mem_ready, grant_d, bus.mem_addr);
        end
        cyc();
        rst_n = 1'b1;
        bus.mem_ready   = 1'b0;
        bus.i_mem_valid = 1'b1;
        bus.i_mem_addr  = 28'h0055550;
        #1;
        checks++;
        if (bus.mem_valid !== 1'b0 || grant_d !== 1'b0) begin
            failures++;
            $display("FAIL midrst_idle: vld=%b gd=%b want 0 0", bus.mem_valid, grant_d);
        end
        cyc();
        checks++;
        if (grant_d !== 1'b0 || bus.mem_valid !== 1'b1 || bus.mem_addr !== 28'h0055550) begin
            failures++;
            $display("FAIL midrst_i_first: gd=%b vld=%b addr=%h want 0 1 0055550", grant_d, bus.mem_valid, bus.mem_addr);
        end
        idle_inputs();
        cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        #1;
        test_reset();
        test_lone_i_read();
        test_simultaneous();
        test_flush();
        test_wb_allocate();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
